// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: FSM state encoding and parameter defaults.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETUP    = 2'd1,
    TRANSFER = 2'd2,
    HOLD     = 2'd3
  } spi_state_e;

  localparam int SPI_CLK_DIV_DEFAULT = 4;
  localparam int SPI_DATA_W_DEFAULT  = 8;

endpackage

// File: rtl/spi_clk_en_gen.sv
// Half-period tick generator: one-cycle tick every CLK_DIV PCLK cycles, restartable via clear.
module spi_clk_en_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = SPI_CLK_DIV_DEFAULT
) (
  input  logic PCLK,
  input  logic PRESET,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV + 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge PCLK) begin
    if (PRESET || clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/spi_master_shifter.sv
// SPI master: one DATA_W-bit full-duplex frame per accepted start, MSB first, modes set by CPOL/CPHA.
// done pulses CLK_DIV*(2*DATA_W+2)+1 cycles after start; start is ignored while busy.
module spi_master_shifter
  import spi_pkg::*;
#(
  parameter int CLK_DIV = SPI_CLK_DIV_DEFAULT,
  parameter int DATA_W  = SPI_DATA_W_DEFAULT,
  parameter bit CPOL    = 1'b0,
  parameter bit CPHA    = 1'b0
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              SCLK,
  output logic              MOSI,
  input  logic              MISO,
  output logic              SS_n
);

  if (CLK_DIV < 1 || DATA_W < 1) begin : g_param_check
    $error("spi_master_shifter: CLK_DIV and DATA_W must both be at least 1");
  end

  localparam int EW = $clog2(2 * DATA_W + 1);

  spi_state_e        state, state_nxt;
  logic [EW-1:0]     edge_cnt;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic              tick;
  logic              clear;
  logic              xfer_tick;
  logic              lead_edge;
  logic              trail_edge;
  logic              last_edge;
  logic              shift_out;
  logic              sample_in;

  spi_clk_en_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_en (
    .PCLK  (PCLK),
    .PRESET(PRESET),
    .clear (clear),
    .tick  (tick)
  );

  // Edge numbering starts at 1, so an even edge_cnt means the coming edge is odd (leading).
  assign xfer_tick  = tick && (state == TRANSFER);
  assign lead_edge  = xfer_tick && !edge_cnt[0];
  assign trail_edge = xfer_tick && edge_cnt[0];
  assign last_edge  = (edge_cnt == EW'(2 * DATA_W - 1));
  assign shift_out  = CPHA ? lead_edge : (trail_edge && !last_edge);
  assign sample_in  = CPHA ? trail_edge : lead_edge;

  assign busy  = (state != IDLE);
  assign clear = (state_nxt != state);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = SETUP;
      SETUP:    if (tick) state_nxt = TRANSFER;
      TRANSFER: if (tick && last_edge) state_nxt = HOLD;
      HOLD:     if (tick) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state    <= IDLE;
      SCLK     <= CPOL;
      SS_n     <= 1'b1;
      MOSI     <= 1'b0;
      done     <= 1'b0;
      rx_data  <= '0;
      edge_cnt <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;

      if (state == IDLE && start) begin
        SS_n     <= 1'b0;
        SCLK     <= CPOL;
        edge_cnt <= '0;
        rx_sr    <= '0;
        // CPHA=0 presents the MSB before the first edge; CPHA=1 drives it on edge 1.
        if (CPHA) begin
          tx_sr <= tx_data;
          MOSI  <= 1'b0;
        end else begin
          tx_sr <= tx_data << 1;
          MOSI  <= tx_data[DATA_W-1];
        end
      end

      if (xfer_tick) begin
        SCLK     <= ~SCLK;
        edge_cnt <= edge_cnt + EW'(1);
      end

      if (shift_out) begin
        MOSI  <= tx_sr[DATA_W-1];
        tx_sr <= tx_sr << 1;
      end

      if (sample_in) begin
        rx_sr <= DATA_W'({rx_sr, MISO});
      end

      if (state == HOLD && tick) begin
        SS_n    <= 1'b1;
        done    <= 1'b1;
        rx_data <= rx_sr;
        MOSI    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_shifter.sv
// Self-checking bench: default-mode instance with a done scoreboard plus a CPOL=1/CPHA=1/CLK_DIV=1 instance.
module tb_spi_master_shifter;

  logic       PCLK = 1'b0;
  logic       PRESET;
  logic       start0, start1;
  logic [7:0] tx0, tx1;
  logic       busy0, done0, sclk0, mosi0, miso0, ss_n0;
  logic       busy1, done1, sclk1, mosi1, miso1, ss_n1;
  logic [7:0] rx0, rx1;
  int         miso_mode;

  always #5 PCLK = ~PCLK;

  // 0: loopback, 1: inverted loopback, 2: tied low, 3: tied high
  assign miso0 = (miso_mode == 0) ? mosi0 :
                 (miso_mode == 1) ? ~mosi0 :
                 (miso_mode == 2) ? 1'b0 : 1'b1;
  assign miso1 = 1'b1;

  spi_master_shifter dut0 (
    .PCLK(PCLK), .PRESET(PRESET), .start(start0), .tx_data(tx0),
    .busy(busy0), .done(done0), .rx_data(rx0),
    .SCLK(sclk0), .MOSI(mosi0), .MISO(miso0), .SS_n(ss_n0)
  );

  spi_master_shifter #(.CLK_DIV(1), .DATA_W(8), .CPOL(1'b1), .CPHA(1'b1)) dut1 (
    .PCLK(PCLK), .PRESET(PRESET), .start(start1), .tx_data(tx1),
    .busy(busy1), .done(done1), .rx_data(rx1),
    .SCLK(sclk1), .MOSI(mosi1), .MISO(miso1), .SS_n(ss_n1)
  );

  typedef struct {
    logic [7:0] tx;
    logic [7:0] rx;
    int         done_cyc;
  } exp_t;

  typedef struct {
    logic [7:0] tx;
    int         mode;
    logic [7:0] rx;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[5];

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int done_cnt0 = 0;

  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) step();
  endtask

  task automatic wait_done0(input int budget);
    int n;
    n = 0;
    while (!done0 && n < budget) begin
      step();
      n++;
    end
    check("done0_within_budget", done0, 1'b1);
  endtask

  // Monitor for dut0: SCLK legality, MOSI capture on leading edges, done scoreboard.
  logic       prev_sclk0 = 1'b0;
  logic       prev_ss0 = 1'b1;
  logic       rst_edge;
  int         last_tog = 0;
  int         edges0 = 0;
  logic [7:0] mosi_cap0 = 8'h00;
  exp_t       e;

  always @(posedge PCLK) begin
    rst_edge = PRESET;
    #1;
    if (rst_edge) begin
      edges0 = 0;
    end else begin
      if (prev_ss0 && !ss_n0) begin
        edges0    = 0;
        mosi_cap0 = 8'h00;
      end
      if (sclk0 !== prev_sclk0) begin
        check("sclk_toggle_with_ss_low", ss_n0, 1'b0);
        if (edges0 > 0) check("sclk_half_period", cyc - last_tog, 4);
        if (sclk0) mosi_cap0 = {mosi_cap0[6:0], mosi0};
        edges0++;
        last_tog = cyc;
      end
      if (done0 === 1'b1) begin
        done_cnt0++;
        n_tests++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_done: done pulse at cycle %0d, expected none", cyc);
        end else begin
          e = sb_q.pop_front();
          check("done_cycle", cyc, e.done_cyc);
          check("rx_data", rx0, e.rx);
          check("mosi_bits", mosi_cap0, e.tx);
          check("sclk_edge_count", edges0, 16);
          check("ss_n_at_done", ss_n0, 1'b1);
          check("busy_at_done", busy0, 1'b0);
          check("sclk_idle_at_done", sclk0, 1'b0);
        end
      end
    end
    prev_sclk0 = sclk0;
    prev_ss0   = ss_n0;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         c;
    int         d0;
    int         tog;
    int         last1;
    logic [7:0] cap1;
    logic       ps;

    PRESET = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    tx0 = 8'h00;
    tx1 = 8'h00;
    miso_mode = 0;

    vecs[0] = '{tx: 8'hA5, mode: 0, rx: 8'hA5};
    vecs[1] = '{tx: 8'h3C, mode: 1, rx: 8'hC3};
    vecs[2] = '{tx: 8'h00, mode: 3, rx: 8'hFF};
    vecs[3] = '{tx: 8'hFF, mode: 2, rx: 8'h00};
    vecs[4] = '{tx: 8'h96, mode: 0, rx: 8'h96};

    step();
    step();
    check("rst_sclk0", sclk0, 1'b0);
    check("rst_ss_n0", ss_n0, 1'b1);
    check("rst_mosi0", mosi0, 1'b0);
    check("rst_busy0", busy0, 1'b0);
    check("rst_done0", done0, 1'b0);
    check("rst_rx0", rx0, 8'h00);
    check("rst_sclk1_cpol1", sclk1, 1'b1);
    check("rst_ss_n1", ss_n1, 1'b1);
    PRESET = 1'b0;
    step();

    // Table-driven single frames with different MISO patterns.
    for (int i = 0; i < 5; i++) begin
      miso_mode = vecs[i].mode;
      tx0 = vecs[i].tx;
      start0 = 1'b1;
      c = cyc;
      sb_q.push_back('{tx: vecs[i].tx, rx: vecs[i].rx, done_cyc: c + 73});
      step();
      start0 = 1'b0;
      tx0 = ~vecs[i].tx;
      check("setup_ss_n_low", ss_n0, 1'b0);
      check("setup_busy", busy0, 1'b1);
      check("setup_mosi_msb", mosi0, vecs[i].tx[7]);
      check("setup_sclk_cpol", sclk0, 1'b0);
      wait_done0(100);
      step();
    end

    // start pulsed mid-frame is ignored.
    miso_mode = 0;
    tx0 = 8'hC3;
    start0 = 1'b1;
    c = cyc;
    d0 = done_cnt0;
    sb_q.push_back('{tx: 8'hC3, rx: 8'hC3, done_cyc: c + 73});
    step();
    start0 = 1'b0;
    wait_cyc(c + 10);
    tx0 = 8'h0F;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    check("busy_while_start_ignored", busy0, 1'b1);
    wait_done0(100);
    wait_cyc(cyc + 80);
    check("single_done_pulse", done_cnt0 - d0, 1);

    // start held through done: back-to-back frames.
    tx0 = 8'h11;
    start0 = 1'b1;
    c = cyc;
    sb_q.push_back('{tx: 8'h11, rx: 8'h11, done_cyc: c + 73});
    sb_q.push_back('{tx: 8'h22, rx: 8'h22, done_cyc: c + 146});
    step();
    tx0 = 8'h22;
    wait_cyc(c + 72);
    check("b2b_ss_low_before_done", ss_n0, 1'b0);
    step();
    check("b2b_ss_high_at_done", ss_n0, 1'b1);
    check("b2b_done_at_t73", done0, 1'b1);
    step();
    start0 = 1'b0;
    check("b2b_ss_low_next_frame", ss_n0, 1'b0);
    check("b2b_busy_next_frame", busy0, 1'b1);
    check("b2b_mosi_msb_0x22", mosi0, 1'b0);
    wait_done0(100);
    step();

    // Reset in mid-frame, with start asserted alongside it.
    tx0 = 8'h5A;
    start0 = 1'b1;
    c = cyc;
    d0 = done_cnt0;
    step();
    start0 = 1'b0;
    wait_cyc(c + 30);
    PRESET = 1'b1;
    start0 = 1'b1;
    step();
    check("abort_ss_n", ss_n0, 1'b1);
    check("abort_sclk", sclk0, 1'b0);
    check("abort_busy", busy0, 1'b0);
    check("abort_done", done0, 1'b0);
    check("abort_rx", rx0, 8'h00);
    check("abort_mosi", mosi0, 1'b0);
    PRESET = 1'b0;
    start0 = 1'b0;
    step();
    check("start_with_reset_ignored", busy0, 1'b0);
    wait_cyc(c + 120);
    check("abort_no_done", done_cnt0 - d0, 0);
    check("abort_rx_held", rx0, 8'h00);

    // CPOL=1, CPHA=1, CLK_DIV=1 instance with MISO tied high.
    check("dut1_idle_sclk_high", sclk1, 1'b1);
    tx1 = 8'h3C;
    start1 = 1'b1;
    c = cyc;
    step();
    start1 = 1'b0;
    tx1 = 8'h00;
    check("dut1_setup_sclk", sclk1, 1'b1);
    check("dut1_setup_ss_n", ss_n1, 1'b0);
    check("dut1_setup_busy", busy1, 1'b1);
    tog = 0;
    last1 = 0;
    cap1 = 8'h00;
    ps = sclk1;
    for (int n = 0; n < 40 && !done1; n++) begin
      step();
      if (sclk1 !== ps) begin
        check("dut1_toggle_ss_low", ss_n1, 1'b0);
        if (tog > 0) check("dut1_half_period", cyc - last1, 1);
        if (sclk1) cap1 = {cap1[6:0], mosi1};
        tog++;
        last1 = cyc;
      end
      ps = sclk1;
    end
    check("dut1_done", done1, 1'b1);
    check("dut1_done_cycle", cyc, c + 19);
    check("dut1_rx", rx1, 8'hFF);
    check("dut1_edges", tog, 16);
    check("dut1_mosi_bits", cap1, 8'h3C);
    check("dut1_sclk_idle", sclk1, 1'b1);
    check("dut1_ss_n_done", ss_n1, 1'b1);
    check("dut1_busy_done", busy1, 1'b0);
    step();

    check("scoreboard_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_master_shifter.md
SPI_MASTER_SHIFTER -- requirements
Module: spi_master_shifter

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4, giving the SCLK half-period in PCLK cycles; the legal range is 1 or more.
REQ-002 The block SHALL have parameter DATA_W, default 8, giving the frame length in bits.
REQ-003 The block SHALL have parameter CPOL, default 0, giving the SCLK idle level.
REQ-004 The block SHALL have parameter CPHA, default 0: 0 samples MISO on the leading edge, 1 samples on the trailing edge.
REQ-005 Port PCLK, input, 1 bit: the single clock; every flop SHALL be clocked on its rising edge.
REQ-006 Port PRESET, input, 1 bit: synchronous, active-high reset.
REQ-007 Port start, input, 1 bit: request a transfer; sampled only while busy=0.
REQ-008 Port tx_data, input, DATA_W bits: frame to send, MSB first, captured in the cycle start is accepted.
REQ-009 Port busy, output, 1 bit: high from the cycle after acceptance until done is asserted.
REQ-010 Port done, output, 1 bit: one-cycle pulse at the end of the frame.
REQ-011 Port rx_data, output, DATA_W bits: received frame; updated only in the cycle done asserts, held otherwise.
REQ-012 Port SCLK, output, 1 bit: serial clock; registered and glitch-free.
REQ-013 Port MOSI, output, 1 bit: serial data out; registered.
REQ-014 Port MISO, input, 1 bit: serial data in; synchronous to PCLK, no synchronizer inside the block.
REQ-015 Port SS_n, output, 1 bit: slave select, active-low; registered.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, SETUP, TRANSFER, HOLD.
REQ-017 In IDLE with start=1 in cycle T, the block SHALL latch tx_data into the shift register and enter SETUP at T+1.
REQ-018 In SETUP, SS_n SHALL be 0 and SCLK SHALL equal CPOL; with CPHA=0, MOSI SHALL equal tx_data MSB from T+1.
REQ-019 The block SHALL stay in SETUP for CLK_DIV cycles, then enter TRANSFER.
REQ-020 In TRANSFER, SCLK SHALL toggle every CLK_DIV cycles, for exactly 2*DATA_W edges.
REQ-021 Odd-numbered edges are leading and even-numbered edges are trailing.
REQ-022 Edge rule for CPHA=0: sample MISO on the leading edge; shift the next bit onto MOSI on the trailing edge, except after the final edge.
REQ-023 Edge rule for CPHA=1: shift the next bit onto MOSI on the leading edge (MSB on edge 1); sample MISO on the trailing edge.
REQ-024 MISO SHALL be sampled in the same PCLK cycle that the SCLK register toggles.
REQ-025 After the 2*DATA_W-th edge, the block SHALL enter HOLD with SCLK=CPOL and SS_n=0, and stay there for CLK_DIV cycles.
REQ-026 On leaving HOLD, the block SHALL return to IDLE. In that same cycle: SS_n=1, done=1, busy=0, and rx_data takes the received frame.
REQ-027 done SHALL assert at cycle T+1+CLK_DIV*(2*DATA_W+2); for the defaults this is T+73.
REQ-028 start while busy=1 SHALL be ignored, with no queueing.
REQ-029 start in the same cycle done=1 SHALL be accepted, so frames run back-to-back with SS_n high for exactly one cycle.
REQ-030 In IDLE: SCLK=CPOL, SS_n=1, MOSI=0, busy=0.
REQ-031 The half-period counter SHALL be $clog2(CLK_DIV+1) bits wide and SHALL clear on every state entry.
REQ-032 The edge counter SHALL be $clog2(2*DATA_W+1) bits wide, with no wrap-around inside a frame.
REQ-033 CLK_DIV=0 or DATA_W<1 SHALL cause an elaboration-time error.

Reset
REQ-034 When PRESET=1 at a PCLK edge, the block SHALL set: state=IDLE, SCLK=CPOL, SS_n=1, MOSI=0, busy=0, done=0, rx_data=0, and both counters to 0.
REQ-035 Reset in mid-frame SHALL abort the frame, produce no done pulse, and leave rx_data at 0.
REQ-036 start asserted together with PRESET SHALL be ignored.

Structure
REQ-037 Package spi_pkg SHALL hold the FSM state enum (IDLE, SETUP, TRANSFER, HOLD) and the default values of CLK_DIV and DATA_W.
REQ-038 The half-period tick generator SHALL be a sub-module, spi_clk_en_gen. It takes parameter CLK_DIV and inputs PCLK, PRESET and clear, and outputs a one-cycle tick every CLK_DIV cycles.
REQ-039 The shift register, edge counter and FSM SHALL live in spi_master_shifter.

Verification
REQ-040 Defaults, start with tx_data=0xA5, MISO looped to MOSI: SS_n falls at T+1, 16 SCLK edges of period 8 PCLK follow, done=1 at T+73, rx_data=0xA5, MOSI bits are 1,0,1,0,0,1,0,1.
REQ-041 CPOL=1, CPHA=1, CLK_DIV=1, MISO tied to 1, tx_data=0x3C: SCLK idles high, done at T+19, rx_data=0xFF.
REQ-042 start pulsed at T+10 while busy: no effect, and exactly one done pulse is seen.
REQ-043 start held high through done, with tx_data 0x11 then 0x22: two frames, SS_n high for exactly one cycle between them, done pulses at T+73 and T+146.
REQ-044 PRESET at T+30 mid-frame: next cycle SS_n=1, SCLK=CPOL, busy=0, no done, rx_data=0.
REQ-045 Throughout all scenarios: SCLK toggles only while SS_n=0, and the SCLK high and low times are each exactly CLK_DIV cycles.
